// File: rtl/deframer_pkg.sv
// Shared types for the stream deframer: FSM states, lane count and frame layout.
package deframer_pkg;

  localparam int LANES = 4;

  typedef enum logic {
    HUNT    = 1'b0,
    COLLECT = 1'b1
  } state_t;

  // lane[0] is the byte that arrived with in_sof; lane[3] completes the frame
  typedef struct packed {
    logic [LANES-1:0][7:0] lane;
  } frame_t;

endpackage

// File: rtl/deframer_fifo.sv
// Frame-wide synchronous FIFO. Output reads as zero while empty so the
// consumer-facing lanes sit at 8'h00 after reset and between frames.
module deframer_fifo
  import deframer_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  frame_t din,
  output logic   full,
  input  logic   pop,
  output frame_t dout,
  output logic   empty
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  frame_t        mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          do_push, do_pop;

  // a push into a full FIFO is legal only when the head leaves in the same cycle
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign dout    = empty ? '0 : mem[rd_ptr];

  // storage write; contents need no reset because empty gates the output
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // pointers wrap naturally since depth is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/stream_deframer.sv
// Reassembles 4-byte time-multiplexed frames (slot 0 marked by in_sof) into
// parallel lanes and buffers them in a small FIFO. Framing errors raise a
// one-cycle frame_err pulse. Define DEFRAMER_STATS_EN to add saturating
// frame_cnt / err_cnt outputs.
module stream_deframer
  import deframer_pkg::*;
#(
  parameter int FIFO_DEPTH = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_sof,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic [7:0] out0,
  output logic [7:0] out1,
  output logic [7:0] out2,
  output logic [7:0] out3,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_err
`ifdef DEFRAMER_STATS_EN
  ,
  output logic [7:0] frame_cnt,
  output logic [7:0] err_cnt
`endif
);

  state_t                state, state_nx;
  logic [1:0]            slot, slot_nx;
  logic [LANES-1:0][7:0] lanes;
  logic                  lane_we;
  logic [1:0]            lane_idx;
  logic                  err_nx, push, pop, accept;
  logic                  fifo_full, fifo_empty;
  frame_t                push_frame, head;

  assign pop       = out_valid && out_ready;
  assign in_ready  = !fifo_full || pop;
  assign accept    = in_valid && in_ready;
  assign out_valid = !fifo_empty;
  assign out0      = head.lane[0];
  assign out1      = head.lane[1];
  assign out2      = head.lane[2];
  assign out3      = head.lane[3];

  // slot-3 byte goes straight into the FIFO alongside the three held lanes
  always_comb begin
    push_frame.lane    = lanes;
    push_frame.lane[3] = in_data;
  end

  // next-state, lane write select, error and push decode
  always_comb begin
    state_nx = state;
    slot_nx  = slot;
    lane_we  = 1'b0;
    lane_idx = slot;
    err_nx   = 1'b0;
    push     = 1'b0;
    if (accept) begin
      case (state)
        HUNT: begin
          if (in_sof) begin
            lane_we  = 1'b1;
            lane_idx = 2'd0;
            slot_nx  = 2'd1;
            state_nx = COLLECT;
          end else begin
            err_nx = 1'b1;
          end
        end
        COLLECT: begin
          if (in_sof) begin
            // restart on the new sof; the partial frame is dropped
            err_nx   = 1'b1;
            lane_we  = 1'b1;
            lane_idx = 2'd0;
            slot_nx  = 2'd1;
          end else if (slot == 2'd3) begin
            push     = 1'b1;
            slot_nx  = 2'd0;
            state_nx = HUNT;
          end else begin
            lane_we = 1'b1;
            slot_nx = slot + 2'd1;
          end
        end
        default: state_nx = HUNT;
      endcase
    end
  end

  // FSM state and slot counter
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= HUNT;
      slot  <= 2'd0;
    end else begin
      state <= state_nx;
      slot  <= slot_nx;
    end
  end

  // per-lane holding registers for slots 0..2 of the frame in progress
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    always_ff @(posedge clk) begin
      if (rst)                                lanes[i] <= 8'h00;
      else if (lane_we && lane_idx == 2'(i))  lanes[i] <= in_data;
    end
  end

  // error pulse lands one cycle after the offending beat
  always_ff @(posedge clk) begin
    if (rst) frame_err <= 1'b0;
    else     frame_err <= err_nx;
  end

  deframer_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (push_frame),
    .full  (fifo_full),
    .pop   (pop),
    .dout  (head),
    .empty (fifo_empty)
  );

`ifdef DEFRAMER_STATS_EN
  // saturating counters of pushed frames and error pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= 8'h00;
      err_cnt   <= 8'h00;
    end else begin
      if (push && frame_cnt != 8'hFF) frame_cnt <= frame_cnt + 8'd1;
      if (frame_err && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: doc/stream_deframer.md
STREAM_DEFRAMER -- requirements
Module: stream_deframer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, number of reassembled frames buffered (power of two, 2..8).
REQ-002 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port in_valid  input  1  in_data/in_sof carry a byte this cycle.
REQ-005 SHALL have port in_sof  input  1  byte is slot 0 of a 4-byte frame.
REQ-006 SHALL have port in_data  input  8  time-multiplexed byte from the mux stage.
REQ-007 SHALL have port in_ready  output  1  block accepts a byte this cycle; a beat transfers when in_valid and in_ready are both high.
REQ-008 SHALL have ports out0, out1, out2, out3  output  8 each  reassembled lanes 0..3 of the head frame.
REQ-009 SHALL have port out_valid  output  1  head frame valid.
REQ-010 SHALL have port out_ready  input  1  consumer takes the head frame; a frame transfers when out_valid and out_ready are both high.
REQ-011 SHALL have port frame_err  output  1  one-cycle pulse on framing error.

Function
REQ-012 SHALL implement FSM HUNT/COLLECT with 2-bit slot counter.
REQ-013 In HUNT, an accepted beat with in_sof=1 SHALL store in_data to lane 0, set slot=1, go to COLLECT.
REQ-014 In HUNT, an accepted beat with in_sof=0 SHALL be discarded and pulse frame_err next cycle.
REQ-015 In COLLECT, an accepted beat with in_sof=0 SHALL store to lane[slot] and increment slot.
REQ-016 In COLLECT, an accepted beat with in_sof=1 SHALL pulse frame_err, discard the partial frame, store the byte as lane 0, set slot=1, stay in COLLECT.
REQ-017 Accepting the slot-3 beat SHALL push the 4 lanes into the FIFO as one entry and return the FSM to HUNT.
REQ-018 out_valid SHALL rise the cycle after the slot-3 beat when the FIFO was empty (latency 1).
REQ-019 in_ready SHALL be low only when the FIFO is full and no pop occurs this cycle; a push and pop in the same cycle on a full FIFO SHALL both succeed.
REQ-020 out0..out3 SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 in_valid=0 cycles SHALL not change FSM, slot or lanes; there is no timeout.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL never exceed FIFO_DEPTH.

Reset
REQ-023 On rst=1 at a clock edge: FSM=HUNT, slot=0, FIFO empty, out_valid=0, frame_err=0, in_ready=1, out0..out3=8'h00.
REQ-024 rst mid-frame SHALL discard the partial frame and all buffered frames without a frame_err pulse.

Configuration
REQ-025 Macro DEFRAMER_STATS_EN defined: SHALL add outputs frame_cnt (8 bits) and err_cnt (8 bits), saturating at 8'hFF, incremented per FIFO push and per frame_err pulse respectively, cleared by rst.
REQ-026 Macro undefined: those ports and counters SHALL be absent; all other behaviour is identical.

Structure
REQ-027 Package deframer_pkg SHALL hold the FSM state enum, LANES=4, and the frame struct type (four 8-bit lanes).
REQ-028 Sub-module deframer_fifo (frame-wide synchronous FIFO, parameter FIFO_DEPTH) SHALL implement buffering; the FSM and lane registers SHALL live in stream_deframer.

Verification
REQ-029 Scenario 1: out_ready=1; beats AA(sof), BB, CC, DD on consecutive cycles -> one cycle later out_valid=1 with out0..3 = AA, BB, CC, DD; frame_err never pulses.
REQ-030 Scenario 2: beats 11(sof), 22, then 33(sof), 44, 55, 66 -> single frame_err pulse; output frame = 33, 44, 55, 66.
REQ-031 Scenario 3: out_ready=0; send three frames with FIFO_DEPTH=2 -> in_ready low after the 2nd push; 3rd frame completes only after out_ready=1; frames are output in order.
REQ-032 Scenario 4: beats 77, 88 with no sof, then 99(sof), A0, A1, A2 -> two frame_err pulses; output frame = 99, A0, A1, A2.
REQ-033 Scenario 5: rst asserted after beats C0(sof), C1 -> outputs at reset values; next frame D0(sof), D1, D2, D3 output intact.
REQ-034 Scenario 6 (DEFRAMER_STATS_EN): 300 good frames -> frame_cnt=8'hFF (saturated); err_cnt=0.
